// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit stack CPU.
// Holds the bus widths, the fetch state encoding and the literal opcode prefix.
package cpu_pkg;

   localparam int ADDR_W  = 16;
   localparam int INSTR_W = 18;

   localparam logic [1:0] OPC_DT = 2'b00;

   typedef enum logic [1:0] {
      FS_IDLE = 2'd0,
      FS_RUN  = 2'd1,
      FS_DONE = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the fetch PC, addresses the program ROM
// and holds the fetched word in a valid/ready instruction register.
module fetch_sequencer
   import cpu_pkg::*;
#(
   parameter int ADDR_W   = cpu_pkg::ADDR_W,
   parameter int INSTR_W  = cpu_pkg::INSTR_W,
   parameter int PROG_LEN = 11
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_run,
   input  logic              i_halt_req,
   input  logic              i_jump,
   input  logic [0:ADDR_W-1] i_jump_addr,
   output logic [0:ADDR_W-1] o_rom_addr,
   input  logic [0:INSTR_W-1] i_rom_instr,
   output logic [0:INSTR_W-1] o_instr,
   output logic [0:ADDR_W-1] o_pc,
   output logic              o_instr_valid,
   input  logic              i_instr_ready,
   output logic              o_is_data,
   output logic              o_halted
);

   fetch_state_e       state_q, state_d;
   logic [0:ADDR_W-1]  fetch_pc_q, fetch_pc_d;
   logic [0:ADDR_W-1]  pc_q, pc_d;
   logic [0:INSTR_W-1] instr_q, instr_d;
   logic               valid_q, valid_d;
   logic               in_range;
   logic               xfer;
   logic               load;

   assign in_range = (fetch_pc_q < ADDR_W'(PROG_LEN));
   assign xfer     = valid_q & i_instr_ready;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      valid_d    = valid_q;
      load       = 1'b0;
      if (xfer)
         valid_d = 1'b0;
      if (i_jump) begin
         // Redirect flushes the held word; the decoder still counts a
         // transfer that coincides with it.
         fetch_pc_d = i_jump_addr;
         valid_d    = 1'b0;
         if (state_q == FS_DONE)
            state_d = FS_RUN;
      end else begin
         unique case (state_q)
            FS_IDLE: begin
               if (i_run)
                  state_d = FS_RUN;
            end
            FS_RUN: begin
               if (i_halt_req)
                  state_d = FS_IDLE;
               else if (!in_range && !valid_q)
                  state_d = FS_DONE;
               else
                  load = in_range & (~valid_q | i_instr_ready);
            end
            FS_DONE: ;
            default: state_d = FS_IDLE;
         endcase
      end
      if (load) begin
         instr_d    = i_rom_instr;
         pc_d       = fetch_pc_q;
         valid_d    = 1'b1;
         fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= FS_IDLE;
         fetch_pc_q <= '0;
         pc_q       <= '0;
         instr_q    <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         valid_q    <= valid_d;
      end
   end

   assign o_rom_addr    = in_range ? fetch_pc_q : '0;
   assign o_instr       = instr_q;
   assign o_pc          = pc_q;
   assign o_instr_valid = valid_q;
   assign o_is_data     = (instr_q[0:1] == OPC_DT);
   assign o_halted      = (state_q == FS_DONE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios feed a scoreboard queue that
// a negedge monitor drains on every decoder transfer.
module tb_fetch_sequencer;

   typedef struct {
      int pc;
      int instr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        run, halt_req, jump, ready;
   logic [0:15] jump_addr;
   logic [0:15] rom_addr;
   logic [0:17] rom_instr;
   logic [0:17] instr;
   logic [0:15] pc;
   logic        valid, is_data, halted;

   logic [17:0] rom [0:10];
   exp_t        exp_q [$];
   int          total = 0;
   int          passed = 0;
   int          max_addr = 0;
   bit          saw_valid = 1'b0;

   always #5 clk = ~clk;

   assign rom_instr = (rom_addr < 16'd11) ? rom[rom_addr] : 18'd0;

   fetch_sequencer dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_run         (run),
      .i_halt_req    (halt_req),
      .i_jump        (jump),
      .i_jump_addr   (jump_addr),
      .o_rom_addr    (rom_addr),
      .i_rom_instr   (rom_instr),
      .o_instr       (instr),
      .o_pc          (pc),
      .o_instr_valid (valid),
      .i_instr_ready (ready),
      .o_is_data     (is_data),
      .o_halted      (halted)
   );

   task automatic chk(input string name, input bit ok,
                      input int act, input int req);
      total++;
      if (ok) passed++;
      else $display("FAIL %s: got %0h expected %0h @%0t", name, act, req, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_range(input int a, input int b);
      for (int i = a; i <= b; i++) begin
         exp_t e;
         e.pc    = i;
         e.instr = int'(rom[i]);
         exp_q.push_back(e);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run = 1'b0; halt_req = 1'b0; jump = 1'b0; ready = 1'b0;
      jump_addr = '0;
      exp_q.delete();
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic run_to_done(input string name);
      for (int i = 0; i < 40 && !halted; i++) step();
      chk({name, "_done"}, halted == 1'b1, int'(halted), 1);
      chk({name, "_drained"}, exp_q.size() == 0, exp_q.size(), 0);
   endtask

   // Scoreboard monitor: a transfer happens at the next edge when valid & ready.
   always @(negedge clk) begin
      if (!rst) begin
         if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
         if (valid) saw_valid = 1'b1;
         if (valid && ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_xfer", 1'b0, int'(pc), -1);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("xfer_pc", int'(pc) == e.pc, int'(pc), e.pc);
               chk("xfer_instr", int'(instr) == e.instr, int'(instr), e.instr);
               chk("xfer_is_data", is_data == (e.instr[17:16] == 2'b00),
                   int'(is_data), int'(e.instr[17:16] == 2'b00));
            end
         end
      end
   end

   initial begin
      rom[0]  = 18'b000000000000001110;
      rom[1]  = 18'h2A001;
      rom[2]  = 18'h00005;
      rom[3]  = 18'b000000000000010010;
      rom[4]  = 18'h10003;
      rom[5]  = 18'h30007;
      rom[6]  = 18'h00020;
      rom[7]  = 18'h24001;
      rom[8]  = 18'h0000F;
      rom[9]  = 18'b011010010000000000;
      rom[10] = 18'h3C000;

      // Reset values and full program run
      do_reset();
      chk("rst_valid", valid == 1'b0, int'(valid), 0);
      chk("rst_pc", pc == 16'd0, int'(pc), 0);
      chk("rst_instr", instr == 18'd0, int'(instr), 0);
      chk("rst_is_data", is_data == 1'b1, int'(is_data), 1);
      chk("rst_halted", halted == 1'b0, int'(halted), 0);
      chk("rst_rom_addr", rom_addr == 16'd0, int'(rom_addr), 0);
      run = 1'b1; ready = 1'b1;
      push_range(0, 10);
      step();
      run = 1'b0;
      chk("lat_edge1", valid == 1'b0, int'(valid), 0);
      step();
      chk("lat_edge2", valid == 1'b1, int'(valid), 1);
      chk("first_is_data", is_data == 1'b1, int'(is_data), 1);
      repeat (11) step();
      chk("end_valid_low", valid == 1'b0, int'(valid), 0);
      chk("end_not_yet_halted", halted == 1'b0, int'(halted), 0);
      step();
      chk("end_halted", halted == 1'b1, int'(halted), 1);
      chk("full_drained", exp_q.size() == 0, exp_q.size(), 0);

      // Stall at pc 3
      do_reset();
      run = 1'b1; ready = 1'b1;
      push_range(0, 10);
      step();
      run = 1'b0;
      repeat (4) step();
      chk("stall_pc3", pc == 16'd3, int'(pc), 3);
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_hold_pc", pc == 16'd3, int'(pc), 3);
         chk("stall_hold_instr", instr == 18'b000000000000010010, int'(instr), 18);
         chk("stall_hold_valid", valid && is_data, int'({valid, is_data}), 3);
      end
      ready = 1'b1;
      step();
      chk("stall_next_pc4", valid && pc == 16'd4, int'(pc), 4);
      run_to_done("stall");

      // Jump to 9 while pc 4 is presented
      do_reset();
      run = 1'b1; ready = 1'b1;
      push_range(0, 4);
      push_range(9, 10);
      step();
      run = 1'b0;
      repeat (5) step();
      chk("jmp_pc4", pc == 16'd4, int'(pc), 4);
      jump = 1'b1; jump_addr = 16'd9;
      step();
      jump = 1'b0;
      chk("jmp_flush", valid == 1'b0, int'(valid), 0);
      step();
      chk("jmp_pc9", valid && pc == 16'd9, int'(pc), 9);
      chk("jmp_instr9", instr == 18'b011010010000000000, int'(instr), int'(rom[9]));
      chk("jmp_not_data", is_data == 1'b0, int'(is_data), 0);
      run_to_done("jump");

      // Halt while pc 5 transfers, then resume
      do_reset();
      run = 1'b1; ready = 1'b1;
      push_range(0, 10);
      step();
      run = 1'b0;
      repeat (6) step();
      chk("halt_pc5", pc == 16'd5, int'(pc), 5);
      halt_req = 1'b1;
      step();
      halt_req = 1'b0;
      chk("halt_valid", valid == 1'b0, int'(valid), 0);
      chk("halt_not_done", halted == 1'b0, int'(halted), 0);
      repeat (3) step();
      chk("idle_valid", valid == 1'b0, int'(valid), 0);
      run = 1'b1;
      step();
      run = 1'b0;
      chk("resume_edge1", valid == 1'b0, int'(valid), 0);
      step();
      chk("resume_pc6", valid && pc == 16'd6, int'(pc), 6);
      run_to_done("halt");

      // Asynchronous reset in the middle of a run
      do_reset();
      run = 1'b1; ready = 1'b1;
      push_range(0, 10);
      step();
      run = 1'b0;
      repeat (4) step();
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", valid == 1'b0, int'(valid), 0);
      chk("arst_pc", pc == 16'd0, int'(pc), 0);
      chk("arst_rom_addr", rom_addr == 16'd0, int'(rom_addr), 0);
      exp_q.delete();
      step();
      rst = 1'b0;
      run = 1'b1;
      push_range(0, 10);
      step();
      run = 1'b0;
      step();
      chk("arst_restart_pc0", valid && pc == 16'd0, int'(pc), 0);
      run_to_done("arst");

      // From DONE: jump out of range, then jump to 0
      saw_valid = 1'b0;
      jump = 1'b1; jump_addr = 16'd11;
      step();
      jump = 1'b0;
      chk("oor_run", halted == 1'b0, int'(halted), 0);
      step();
      chk("oor_done", halted == 1'b1, int'(halted), 1);
      chk("oor_no_valid", saw_valid == 1'b0, int'(saw_valid), 0);
      push_range(0, 10);
      jump = 1'b1; jump_addr = 16'd0;
      step();
      jump = 1'b0;
      chk("replay_run", halted == 1'b0, int'(halted), 0);
      run_to_done("replay");

      chk("rom_addr_max", max_addr <= 10, max_addr, 10);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the 16-bit stack CPU.
- Owns the fetch program counter and drives the combinational program ROM address.
- Captures the returned 18-bit instruction into an instruction register and presents it to the decoder with a valid/ready handshake.
- Handles run/pause, jump redirects, and end-of-program termination, so the ROM is never indexed out of range.

Parameters:
- ADDR_W, 16, width of PC and ROM address.
- INSTR_W, 18, instruction width.
- PROG_LEN, 11, number of valid ROM words; addresses >= PROG_LEN are end-of-program.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_run  in  1  start/resume fetching (sampled in IDLE).
- i_halt_req  in  1  pause fetching after draining (sampled in RUN).
- i_jump  in  1  redirect request.
- i_jump_addr  in  [0:ADDR_W-1]  redirect target.
- o_rom_addr  out  [0:ADDR_W-1]  address to program ROM.
- i_rom_instr  in  [0:INSTR_W-1]  combinational ROM data for o_rom_addr.
- o_instr  out  [0:INSTR_W-1]  instruction register.
- o_pc  out  [0:ADDR_W-1]  address of o_instr.
- o_instr_valid  out  1  o_instr is valid.
- i_instr_ready  in  1  decoder accepts o_instr this cycle.
- o_is_data  out  1  o_instr[0:1]==2'b00 (DT literal).
- o_halted  out  1  state DONE.

Behaviour:
- Reset (async, immediate):
  - fetch_pc=0, o_instr=0, o_pc=0, o_instr_valid=0, o_halted=0, state=IDLE.
  - o_is_data follows o_instr combinationally, so it is 1 while o_instr=0.
- o_rom_addr = fetch_pc when fetch_pc < PROG_LEN, else 0. Never out of range.
- Handshake:
  - transfer = o_instr_valid & i_instr_ready.
  - o_instr and o_pc are stable while valid & !ready; no instruction is skipped or duplicated.
- load = state==RUN & fetch_pc<PROG_LEN & (!o_instr_valid | i_instr_ready).
  - On load: o_instr<=i_rom_instr, o_pc<=fetch_pc, valid<=1, fetch_pc<=fetch_pc+1 (mod 2^ADDR_W).
  - Without load, a transfer clears valid.
- Latency: first valid instruction appears 2 edges after i_run is sampled (IDLE->RUN, then load). After that, one instruction per cycle at full throughput with ready held high.
- States:
  - IDLE: no loads; a pending valid instruction still completes its handshake. i_run=1 -> RUN.
  - RUN:
    - i_halt_req=1 -> IDLE; no load that cycle; fetch_pc kept.
    - fetch_pc>=PROG_LEN & valid==0 -> DONE.
  - DONE: o_halted=1, no loads. Exits only on reset or i_jump.
- Jump (any state, highest priority):
  - fetch_pc<=i_jump_addr, valid<=0 (flushes the held instruction; a transfer in the same cycle is still counted by the decoder), no load that cycle.
  - IDLE stays IDLE. RUN stays RUN. DONE -> RUN.
  - If i_jump_addr>=PROG_LEN, RUN proceeds to DONE on the next cycle.
- Priority: reset > jump > halt_req > load. i_run in RUN/DONE and i_halt_req in IDLE/DONE are ignored.
- o_halted = (state==DONE), registered state decode.

Decomposition:
- Shared package `cpu_pkg`:
  - ADDR_W and INSTR_W constants.
  - fetch state enum (IDLE, RUN, DONE).
  - OPC_DT=2'b00 literal-prefix constant.
- No sub-module. The ROM is instantiated beside this block at CPU top level, with o_rom_addr/i_rom_instr wired to it.

Test Plan:
- Reset, i_run pulse, ready=1 with the 11-word program -> o_pc 0..10 on consecutive cycles.
  - First valid on the 2nd edge after run.
  - o_instr[0]=18'b000000000000001110 with o_is_data=1.
  - o_halted=1 one cycle after pc 10 transfers; o_rom_addr never exceeds 10.
- At o_pc=3 hold ready=0 for 3 cycles -> o_instr stays 18'b000000000000010010, o_is_data=1, o_pc=3. Ready high -> next o_pc=4, no gap.
- i_jump with addr 9 while o_pc=4 valid -> valid=0 for one cycle, then o_pc=9 with 18'b011010010000000000, then o_pc=10, then DONE.
- i_halt_req while o_pc=5 transfers -> IDLE, valid drops, o_halted=0. i_run 4 cycles later -> o_pc=6 appears 2 edges later.
- Assert i_rst asynchronously mid-cycle during RUN -> o_instr_valid=0, o_pc=0, o_rom_addr=0 before the next clock edge. Release, then i_run -> fetch restarts at 0.
- From DONE, i_jump with addr 11 -> RUN then DONE, no valid ever asserted. i_jump with addr 0 -> full program replays.
